// File: rtl/msi_pkg.sv
// MSI/MESI controller shared encodings: line states, bus messages, FSM, events.
// MESI_EXCLUSIVE_EN enables the E state; otherwise code 11 recovers to I.
package msi_pkg;

  typedef enum logic [1:0] {
    ST_I = 2'b00,
    ST_M = 2'b01,
    ST_S = 2'b10,
    ST_E = 2'b11
  } line_st_e;

  typedef enum logic [1:0] {
    MSG_INV  = 2'b00,
    MSG_WM   = 2'b01,
    MSG_RM   = 2'b10,
    MSG_NONE = 2'b11
  } bus_msg_e;

  localparam bus_msg_e NONE_CODE = MSG_NONE;

  typedef enum logic [1:0] {
    F_IDLE = 2'b00,
    F_BUS  = 2'b01,
    F_RESP = 2'b10
  } fsm_e;

  typedef enum logic [3:0] {
    EV_NOP,
    EV_RD_HIT,
    EV_WR_HIT,
    EV_RD_MISS,
    EV_WR_MISS,
    EV_FILL_RM,
    EV_FILL_WM,
    EV_SN_RM,
    EV_SN_WM,
    EV_SN_INV
  } ev_e;

  // Without the E state, encoding 11 is illegal and reads as I.
  function automatic line_st_e san_st(input logic [1:0] s);
`ifdef MESI_EXCLUSIVE_EN
    return line_st_e'(s);
`else
    return (s == 2'b11) ? ST_I : line_st_e'(s);
`endif
  endfunction

endpackage

// File: rtl/msi_next_state.sv
// Combinational line transition: state + CPU/snoop event -> next, msg, wb.
// Ports: st_i, ev_i, shared_i in; nxt_o, msg_o, wb_o out. Macro MESI_EXCLUSIVE_EN.
module msi_next_state
  import msi_pkg::*;
(
  input  line_st_e st_i,
  input  ev_e      ev_i,
  input  logic     shared_i,
  output line_st_e nxt_o,
  output bus_msg_e msg_o,
  output logic     wb_o
);

  line_st_e s;

`ifndef MESI_EXCLUSIVE_EN
  logic unused_shared;
  assign unused_shared = shared_i;
`endif

  always_comb begin
    s     = san_st(st_i);
    nxt_o = s;
    msg_o = NONE_CODE;
    wb_o  = 1'b0;
    case (ev_i)
      EV_WR_HIT: begin
        if (s == ST_E) nxt_o = ST_M;
        else if (s == ST_S) msg_o = MSG_INV;
      end
      EV_RD_MISS: begin
        msg_o = MSG_RM;
        wb_o  = (s == ST_M);
      end
      EV_WR_MISS: begin
        msg_o = MSG_WM;
        wb_o  = (s == ST_M);
      end
      EV_FILL_RM: begin
`ifdef MESI_EXCLUSIVE_EN
        nxt_o = shared_i ? ST_S : ST_E;
`else
        nxt_o = ST_S;
`endif
      end
      EV_FILL_WM: nxt_o = ST_M;
      EV_SN_RM: begin
        if (s == ST_M) begin
          nxt_o = ST_S;
          wb_o  = 1'b1;
        end else if (s == ST_E) begin
          nxt_o = ST_S;
        end
      end
      EV_SN_WM: begin
        wb_o  = (s == ST_M);
        nxt_o = ST_I;
      end
      // An INVALIDATE cannot legally target an M line; leave it alone.
      EV_SN_INV: begin
        if (s == ST_S || s == ST_E) nxt_o = ST_I;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/msi_line_array_controller.sv
// Direct-mapped MSI coherence controller: CPU port, snooping bus, write-backs.
// Ports: cpu_req_*/cpu_resp_*, bus_out_*, snoop_*, bus_shared, wb_*. Macro MESI_EXCLUSIVE_EN.
module msi_line_array_controller
  import msi_pkg::*;
#(
  parameter int LINES = 4,
  parameter int TAG_W = 8,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req_valid,
  output logic             cpu_req_ready,
  input  logic             cpu_req_write,
  input  logic [IDX_W-1:0] cpu_req_index,
  input  logic [TAG_W-1:0] cpu_req_tag,
  output logic             cpu_resp_valid,
  output logic             cpu_resp_hit,
  output logic             bus_out_valid,
  input  logic             bus_out_ready,
  output logic [1:0]       bus_out_msg,
  output logic [IDX_W-1:0] bus_out_index,
  output logic [TAG_W-1:0] bus_out_tag,
  input  logic             snoop_valid,
  input  logic [1:0]       snoop_msg,
  input  logic [IDX_W-1:0] snoop_index,
  input  logic [TAG_W-1:0] snoop_tag,
  input  logic             bus_shared,
  output logic             wb_valid,
  output logic [IDX_W-1:0] wb_index,
  output logic [TAG_W-1:0] wb_tag
);

  line_st_e         st_q  [LINES];
  line_st_e         st_d  [LINES];
  logic [TAG_W-1:0] tag_q [LINES];
  logic [TAG_W-1:0] tag_d [LINES];

  fsm_e             fsm_q, fsm_d;
  logic             rv_q, rv_d;
  logic             rh_q, rh_d;
  logic             bv_q, bv_d;
  bus_msg_e         bm_q, bm_d;
  logic [IDX_W-1:0] bi_q, bi_d;
  logic [TAG_W-1:0] bt_q, bt_d;

  logic             accept, hshake;
  logic [IDX_W-1:0] cpu_idx;
  line_st_e         cpu_st, cpu_nxt;
  logic             cpu_hit, cpu_wb;
  ev_e              cpu_ev;
  bus_msg_e         cpu_msg;

  line_st_e         sn_st, sn_nxt;
  logic             sn_match, sn_wb;
  ev_e              sn_ev;
  bus_msg_e         sn_msg;

  assign cpu_req_ready = (fsm_q == F_IDLE) & ~snoop_valid & ~reset;
  assign accept        = cpu_req_ready & cpu_req_valid;
  assign hshake        = (fsm_q == F_BUS) & bus_out_ready;

  // During a pending request the CPU path works on the latched line.
  assign cpu_idx = (fsm_q == F_BUS) ? bi_q : cpu_req_index;
  assign cpu_st  = san_st(st_q[cpu_idx]);
  assign cpu_hit = (cpu_st != ST_I) & (tag_q[cpu_idx] == cpu_req_tag);

  always_comb begin
    cpu_ev = EV_NOP;
    if (accept) begin
      if (cpu_req_write) cpu_ev = cpu_hit ? EV_WR_HIT : EV_WR_MISS;
      else               cpu_ev = cpu_hit ? EV_RD_HIT : EV_RD_MISS;
    end else if (hshake) begin
      cpu_ev = (bm_q == MSG_RM) ? EV_FILL_RM : EV_FILL_WM;
    end
  end

  assign sn_st    = san_st(st_q[snoop_index]);
  assign sn_match = snoop_valid & (sn_st != ST_I) &
                    (tag_q[snoop_index] == snoop_tag);

  always_comb begin
    sn_ev = EV_NOP;
    if (sn_match) begin
      case (bus_msg_e'(snoop_msg))
        MSG_RM:  sn_ev = EV_SN_RM;
        MSG_WM:  sn_ev = EV_SN_WM;
        MSG_INV: sn_ev = EV_SN_INV;
        default: sn_ev = EV_NOP;
      endcase
    end
  end

  msi_next_state u_cpu_ns (
    .st_i     (cpu_st),
    .ev_i     (cpu_ev),
    .shared_i (bus_shared),
    .nxt_o    (cpu_nxt),
    .msg_o    (cpu_msg),
    .wb_o     (cpu_wb)
  );

  msi_next_state u_sn_ns (
    .st_i     (sn_st),
    .ev_i     (sn_ev),
    .shared_i (bus_shared),
    .nxt_o    (sn_nxt),
    .msg_o    (sn_msg),
    .wb_o     (sn_wb)
  );

  logic unused_sn_msg;
  assign unused_sn_msg = ^sn_msg;

  always_comb begin
    st_d  = st_q;
    tag_d = tag_q;
    fsm_d = fsm_q;
    rv_d  = 1'b0;
    rh_d  = 1'b0;
    bv_d  = bv_q;
    bm_d  = bm_q;
    bi_d  = bi_q;
    bt_d  = bt_q;
    if (sn_ev != EV_NOP) st_d[snoop_index] = sn_nxt;
    case (fsm_q)
      F_IDLE: begin
        if (accept) begin
          st_d[cpu_req_index] = cpu_nxt;
          if (cpu_msg == NONE_CODE) begin
            fsm_d = F_RESP;
            rv_d  = 1'b1;
            rh_d  = 1'b1;
          end else begin
            fsm_d = F_BUS;
            bv_d  = 1'b1;
            bm_d  = cpu_msg;
            bi_d  = cpu_req_index;
            bt_d  = cpu_req_tag;
          end
        end
      end
      F_BUS: begin
        if (hshake) begin
          // Fill overrides any same-cycle snoop on this line.
          st_d[bi_q]  = cpu_nxt;
          tag_d[bi_q] = bt_q;
          fsm_d = F_RESP;
          rv_d  = 1'b1;
          bv_d  = 1'b0;
          bm_d  = NONE_CODE;
          bi_d  = '0;
          bt_d  = '0;
        end else if (bm_q == MSG_INV && sn_ev != EV_NOP &&
                     snoop_index == bi_q && sn_nxt == ST_I) begin
          // Lost our S copy: the upgrade must now fetch the line.
          bm_d = MSG_WM;
        end
      end
      F_RESP: fsm_d = F_IDLE;
      default: begin
        fsm_d = F_IDLE;
        bv_d  = 1'b0;
        bm_d  = NONE_CODE;
        bi_d  = '0;
        bt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) begin
        st_q[i]  <= ST_I;
        tag_q[i] <= '0;
      end
      fsm_q <= F_IDLE;
      rv_q  <= 1'b0;
      rh_q  <= 1'b0;
      bv_q  <= 1'b0;
      bm_q  <= NONE_CODE;
      bi_q  <= '0;
      bt_q  <= '0;
    end else begin
      st_q  <= st_d;
      tag_q <= tag_d;
      fsm_q <= fsm_d;
      rv_q  <= rv_d;
      rh_q  <= rh_d;
      bv_q  <= bv_d;
      bm_q  <= bm_d;
      bi_q  <= bi_d;
      bt_q  <= bt_d;
    end
  end

  assign cpu_resp_valid = rv_q;
  assign cpu_resp_hit   = rh_q;
  assign bus_out_valid  = bv_q;
  assign bus_out_msg    = bm_q;
  assign bus_out_index  = bi_q;
  assign bus_out_tag    = bt_q;

  // Victim and snoop write-backs are mutually exclusive by construction.
  always_comb begin
    wb_valid = 1'b0;
    wb_index = '0;
    wb_tag   = '0;
    if (!reset) begin
      if (accept && cpu_wb) begin
        wb_valid = 1'b1;
        wb_index = cpu_req_index;
        wb_tag   = tag_q[cpu_req_index];
      end else if (sn_ev != EV_NOP && sn_wb) begin
        wb_valid = 1'b1;
        wb_index = snoop_index;
        wb_tag   = tag_q[snoop_index];
      end
    end
  end

endmodule

// File: tb/tb_msi_line_array_controller.sv
// Directed scoreboard bench for msi_line_array_controller.
// Build with +define+MESI_EXCLUSIVE_EN to exercise the E-state path.
module tb_msi_line_array_controller;

  localparam logic [1:0] M_INV  = 2'b00;
  localparam logic [1:0] M_WM   = 2'b01;
  localparam logic [1:0] M_RM   = 2'b10;
  localparam logic [1:0] M_NONE = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_req_valid = 1'b0;
  logic       cpu_req_ready;
  logic       cpu_req_write = 1'b0;
  logic [1:0] cpu_req_index = '0;
  logic [7:0] cpu_req_tag = '0;
  logic       cpu_resp_valid, cpu_resp_hit;
  logic       bus_out_valid;
  logic       bus_out_ready = 1'b0;
  logic [1:0] bus_out_msg, bus_out_index;
  logic [7:0] bus_out_tag;
  logic       snoop_valid = 1'b0;
  logic [1:0] snoop_msg = M_NONE;
  logic [1:0] snoop_index = '0;
  logic [7:0] snoop_tag = '0;
  logic       bus_shared = 1'b0;
  logic       wb_valid;
  logic [1:0] wb_index;
  logic [7:0] wb_tag;

  msi_line_array_controller dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_write  (cpu_req_write),
    .cpu_req_index  (cpu_req_index),
    .cpu_req_tag    (cpu_req_tag),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_hit   (cpu_resp_hit),
    .bus_out_valid  (bus_out_valid),
    .bus_out_ready  (bus_out_ready),
    .bus_out_msg    (bus_out_msg),
    .bus_out_index  (bus_out_index),
    .bus_out_tag    (bus_out_tag),
    .snoop_valid    (snoop_valid),
    .snoop_msg      (snoop_msg),
    .snoop_index    (snoop_index),
    .snoop_tag      (snoop_tag),
    .bus_shared     (bus_shared),
    .wb_valid       (wb_valid),
    .wb_index       (wb_index),
    .wb_tag         (wb_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] msg;
    logic [1:0] idx;
    logic [7:0] tag;
  } bus_exp_t;

  bus_exp_t bus_q[$];
  bit       resp_q[$];

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] obs,
                     input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_resp();
    bit h;
    h = resp_q.pop_front();
    chk("resp_valid", cpu_resp_valid, 1);
    chk("resp_hit", cpu_resp_hit, h);
    cyc();
    chk("resp_pulse", cpu_resp_valid, 0);
  endtask

  task automatic bus_phase(input int dly);
    bus_exp_t e;
    logic [11:0] snap;
    bit stable;
    stable = 1'b1;
    e = bus_q.pop_front();
    chk("bus_valid", bus_out_valid, 1);
    chk("bus_msg", bus_out_msg, e.msg);
    chk("bus_idx", bus_out_index, e.idx);
    chk("bus_tag", bus_out_tag, e.tag);
    snap = {bus_out_msg, bus_out_index, bus_out_tag};
    repeat (dly) begin
      cyc();
      if ({bus_out_msg, bus_out_index, bus_out_tag} !== snap ||
          bus_out_valid !== 1'b1) stable = 1'b0;
    end
    chk("bus_hold", stable, 1);
    bus_out_ready = 1'b1;
    cyc();
    bus_out_ready = 1'b0;
    chk("bus_drop", bus_out_valid, 0);
    check_resp();
  endtask

  task automatic cpu_req(input bit wr, input int idx, input int tg,
                         input bit exp_hit, input logic [1:0] exp_msg,
                         input int dly, input bit exp_wb,
                         input int exp_wb_tag);
    int n;
    n = 0;
    cpu_req_valid = 1'b1;
    cpu_req_write = wr;
    cpu_req_index = idx[1:0];
    cpu_req_tag   = tg[7:0];
    #1;
    while (!cpu_req_ready && n < 20) begin
      cyc();
      #1;
      n++;
    end
    chk("req_ready", cpu_req_ready, 1);
    chk("wb_valid_acc", wb_valid, exp_wb);
    if (exp_wb) begin
      chk("wb_tag_acc", wb_tag, exp_wb_tag);
      chk("wb_idx_acc", wb_index, idx);
    end
    resp_q.push_back(exp_hit);
    if (!exp_hit) bus_q.push_back('{exp_msg, idx[1:0], tg[7:0]});
    cyc();
    cpu_req_valid = 1'b0;
    if (exp_hit) begin
      chk("bus_idle_hit", bus_out_valid, 0);
      check_resp();
    end else begin
      bus_phase(dly);
    end
  endtask

  task automatic snoop(input logic [1:0] msg, input int idx, input int tg,
                       input bit exp_wb, input int exp_wb_tag);
    snoop_valid = 1'b1;
    snoop_msg   = msg;
    snoop_index = idx[1:0];
    snoop_tag   = tg[7:0];
    #1;
    chk("snoop_blocks_ready", cpu_req_ready, 0);
    chk("snoop_wb", wb_valid, exp_wb);
    if (exp_wb) chk("snoop_wb_tag", wb_tag, exp_wb_tag);
    cyc();
    snoop_valid = 1'b0;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_bv"}, bus_out_valid, 0);
    chk({nm, "_bm"}, bus_out_msg, M_NONE);
    chk({nm, "_bi"}, bus_out_index, 0);
    chk({nm, "_bt"}, bus_out_tag, 0);
    chk({nm, "_rv"}, cpu_resp_valid, 0);
    chk({nm, "_rh"}, cpu_resp_hit, 0);
    chk({nm, "_wb"}, wb_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    cyc();
    cyc();
    chk_reset_outs("reset");
    reset = 1'b0;
    cyc();

    // Cold read miss, then repeat read hit.
    cpu_req(0, 1, 'h12, 0, M_RM, 3, 0, 0);
    chk("st1_S", dut.st_q[1], 2'b10);
    cpu_req(0, 1, 'h12, 1, M_NONE, 0, 0, 0);

    // Upgrade from S, then silent write hit in M.
    cpu_req(1, 1, 'h12, 0, M_INV, 1, 0, 0);
    cpu_req(1, 1, 'h12, 1, M_NONE, 0, 0, 0);
    chk("st1_M", dut.st_q[1], 2'b01);

    // Conflict miss evicting a dirty victim.
    cpu_req(0, 1, 'h34, 0, M_RM, 2, 1, 'h12);
    chk("st1_S_fill", dut.st_q[1], 2'b10);

    // Dirty line downgraded then invalidated by snoops.
    cpu_req(1, 1, 'h34, 0, M_INV, 0, 0, 0);
    snoop(M_RM, 1, 'h34, 1, 'h34);
    chk("st1_S_snp", dut.st_q[1], 2'b10);
    snoop(M_WM, 1, 'h34, 0, 0);
    chk("st1_I_snp", dut.st_q[1], 2'b00);

    // Last index; a non-matching snoop leaves the line alone.
    cpu_req(0, 3, 'hFF, 0, M_RM, 1, 0, 0);
    snoop(M_WM, 3, 'h00, 0, 0);
    cpu_req(0, 3, 'hFF, 1, M_NONE, 0, 0, 0);

    // Pending INVALIDATE converted to WRITE_MISS by a snoop.
    cpu_req(0, 1, 'h34, 0, M_RM, 0, 0, 0);
    cpu_req_valid = 1'b1;
    cpu_req_write = 1'b1;
    cpu_req_index = 2'd1;
    cpu_req_tag   = 8'h34;
    #1;
    chk("conv_ready", cpu_req_ready, 1);
    resp_q.push_back(1'b0);
    cyc();
    cpu_req_valid = 1'b0;
    chk("conv_bv", bus_out_valid, 1);
    chk("conv_inv", bus_out_msg, M_INV);
    snoop(M_WM, 1, 'h34, 0, 0);
    chk("conv_bv2", bus_out_valid, 1);
    chk("conv_wm", bus_out_msg, M_WM);
    chk("conv_tag", bus_out_tag, 'h34);
    bus_out_ready = 1'b1;
    cyc();
    bus_out_ready = 1'b0;
    check_resp();
    chk("conv_st_M", dut.st_q[1], 2'b01);

    // Reset while a WRITE_MISS waits for the bus.
    cpu_req_valid = 1'b1;
    cpu_req_write = 1'b1;
    cpu_req_index = 2'd2;
    cpu_req_tag   = 8'h56;
    #1;
    chk("rst_ready", cpu_req_ready, 1);
    cyc();
    cpu_req_valid = 1'b0;
    chk("rst_bv", bus_out_valid, 1);
    chk("rst_wm", bus_out_msg, M_WM);
    cyc();
    reset = 1'b1;
    cyc();
    chk_reset_outs("midrst");
    reset = 1'b0;
    cyc();
    // Former dirty line 1 is gone: plain miss, no write-back.
    cpu_req(0, 1, 'h34, 0, M_RM, 0, 0, 0);

    // Exclusive fill when nobody else shares the line.
    bus_shared = 1'b0;
    cpu_req(0, 0, 'h77, 0, M_RM, 1, 0, 0);
`ifdef MESI_EXCLUSIVE_EN
    chk("st0_E", dut.st_q[0], 2'b11);
    cpu_req(1, 0, 'h77, 1, M_NONE, 0, 0, 0);
    chk("st0_M", dut.st_q[0], 2'b01);
`else
    chk("st0_S", dut.st_q[0], 2'b10);
    cpu_req(1, 0, 'h77, 0, M_INV, 0, 0, 0);
    chk("st0_M", dut.st_q[0], 2'b01);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/msi_line_array_controller.md
# msi_line_array_controller

Registered, parametrised MSI coherence controller for a direct-mapped private cache of LINES lines. Holds per-line tag and coherence state, serves one CPU request at a time, and issues bus messages over a valid/ready handshake. It snoops other caches' bus messages every cycle and requests write-backs of dirty victims. It sits between the CPU load/store port and the shared snooping bus, and supersedes the single-line combinational transition logic.

## Interface
- LINES, 4: number of lines; power of two, ≥2.
- TAG_W, 8: tag width.
- IDX_W, $clog2(LINES): derived; not overridden.

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- cpu_req_valid / cpu_req_ready  in / out  1  CPU request handshake.
- cpu_req_write  in  1  1 = write, 0 = read.
- cpu_req_index, cpu_req_tag  in  IDX_W, TAG_W  request address.
- cpu_resp_valid  out  1  one-cycle completion pulse.
- cpu_resp_hit  out  1  1 = completed without a bus message.
- bus_out_valid / bus_out_ready  out / in  1  outgoing bus message handshake.
- bus_out_msg  out  2  INVALIDATE=00, WRITE_MISS=01, READ_MISS=10, NONE=11.
- bus_out_index, bus_out_tag  out  IDX_W, TAG_W  message address.
- snoop_valid  in  1  message from another cache; the own message is never looped back.
- snoop_msg, snoop_index, snoop_tag  in  2, IDX_W, TAG_W.
- bus_shared  in  1  another cache holds the line; sampled on READ_MISS handshake; ignored unless MESI_EXCLUSIVE_EN.
- wb_valid  out  1  one-cycle write-back request pulse.
- wb_index, wb_tag  out  IDX_W, TAG_W  address of the line being written back.

## Operation
- Line states: I=00, M=01, S=10, E=11 (E only with macro). Hit = state≠I and tag equal.
- FSM: IDLE, BUS_REQ, RESP. cpu_req_ready = (FSM==IDLE) & ~snoop_valid; a snoop always wins over a new CPU request.
- Accept in IDLE:
  - read hit (M/S/E), or write hit in M: go to RESP, hit=1, no bus activity.
  - write hit in E (macro): line→M, go to RESP, hit=1.
  - write hit in S: go to BUS_REQ with INVALIDATE.
  - read miss: go to BUS_REQ with READ_MISS. write miss: go to BUS_REQ with WRITE_MISS.
  - On a miss where the victim is M: wb_valid pulses in the accept cycle with the victim's index and old tag.
- On the BUS_REQ handshake: tag←request tag. READ_MISS sets the line to S (E if macro and bus_shared=0). WRITE_MISS and INVALIDATE set it to M. FSM→RESP with hit=0.
- Snoop, applied every cycle in any FSM state when the tag matches and the line state is not I:
  - READ_MISS: M→S with wb pulse; E→S; S unchanged.
  - WRITE_MISS: M→I with wb pulse; S/E→I.
  - INVALIDATE: S/E→I. If it hits a line in M, the line is left unchanged.
- If a snoop invalidates the line under a pending INVALIDATE in BUS_REQ, bus_out_msg changes to WRITE_MISS in the following cycle; this is the only permitted mid-request change.
- Unused encodings (FSM or line state 11 without macro) recover to IDLE / I.

## Timing
- Reset values: all lines I, tags 0, FSM IDLE. All valid outputs 0, bus_out_msg=11, cpu_resp_hit=0, index/tag outputs 0.
- Hit latency: accept at cycle T gives cpu_resp_valid at T+1.
- Miss latency: bus_out_valid is high from T+1. msg/index/tag are held stable until bus_out_ready (except the snoop conversion above). Line update and cpu_resp_valid follow one cycle after the handshake.
- bus_out_valid never drops without a handshake, except on reset. Reset mid-request abandons the request and returns to the reset state in the next cycle.
- wb_valid is at most one pulse per cycle. CPU victim write-backs occur only in accept cycles, which never coincide with snoops.

## Configuration
- MESI_EXCLUSIVE_EN defined: E state enabled; bus_shared is used; a write hit in E upgrades silently to M.
- MESI_EXCLUSIVE_EN undefined: pure MSI; bus_shared is ignored; a READ_MISS fill always sets S.

## Structure
- Package msi_pkg: line-state and bus-message encodings, FSM state enum, NONE code.
- Sub-module msi_next_state: purely combinational. Inputs are the current line state, a CPU or snoop event, and bus_shared. Outputs are the next state, bus message and write-back flag. It is instantiated twice: CPU path and snoop path.

## Test plan
- After reset: read idx1 tag 0x12 → READ_MISS on the bus, ready after 3 cycles, resp hit=0. A repeat read gives resp at T+1 with hit=1.
- Line in S: write → INVALIDATE, then line M. A further write gives hit=1 with no bus activity.
- Line M tag 0x12: read idx1 tag 0x34 → wb_valid with tag 0x12 in the accept cycle, READ_MISS with tag 0x34, line S.
- Line M: snoop READ_MISS with matching tag → wb pulse, line S. A snoop WRITE_MISS then moves the line to I.
- Pending INVALIDATE with bus_out_ready low: a matching snoop WRITE_MISS arrives → bus_out_msg becomes WRITE_MISS and completes with the line in M. Reset asserted mid-wait → all outputs return to reset values.
- With MESI_EXCLUSIVE_EN: read miss with bus_shared=0 → line E. A following write gives hit=1, the line becomes M and no bus message is issued.
